// File: rtl/test_xif_mem_bridge_pkg.sv
// rtl/test_xif_mem_bridge_pkg.sv - XIF memory bridge types, FSM states and exception codes
package test_xif_mem_bridge_pkg;

  localparam int unsigned XIdWidth = 4;

  localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
  localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_COMMIT,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_RESULT
  } bridge_state_e;

  typedef struct packed {
    logic [XIdWidth-1:0] id;
    logic [31:0]         addr;
    logic [1:0]          mode;
    logic                we;
    logic [1:0]          size;
    logic [3:0]          be;
    logic [1:0]          attr;
    logic [31:0]         wdata;
    logic                last;
    logic                spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [XIdWidth-1:0] id;
    logic [31:0]         rdata;
    logic                err;
    logic                dbg;
  } x_mem_result_t;

  typedef struct packed {
    logic [XIdWidth-1:0] id;
    logic                commit_kill;
  } x_commit_t;

  // Halfword must sit on an even byte, word on a word boundary; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
    is_misaligned = ((size == 2'd1) && addr_lsb[0]) ||
                    ((size == 2'd2) && (addr_lsb != 2'b00));
  endfunction

endpackage

// File: rtl/xif_mem_lane_align.sv
// rtl/xif_mem_lane_align.sv - byte-lane enables and data shifting for sub-word accesses
module xif_mem_lane_align (
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    be_o = 4'b1111;
    case (size_i)
      2'd0:    be_o = 4'b0001 << offset_i;
      2'd1:    be_o = 4'b0011 << offset_i;
      default: be_o = 4'b1111;
    endcase
  end

  assign wdata_o = wdata_i << {offset_i, 3'b000};
  assign rdata_o = rdata_i >> {offset_i, 3'b000};

endmodule

// File: rtl/test_xif_mem_bridge.sv
// rtl/test_xif_mem_bridge.sv - single-outstanding XIF memory request to req/gnt/rvalid bus bridge
module test_xif_mem_bridge
  import test_xif_mem_bridge_pkg::*;
#(
  parameter logic CheckAlign = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          x_mem_valid_i,
  output logic          x_mem_ready_o,
  input  x_mem_req_t    x_mem_req_i,
  output x_mem_resp_t   x_mem_resp_o,
  output logic          x_mem_result_valid_o,
  output x_mem_result_t x_mem_result_o,
  input  logic          x_commit_valid_i,
  input  x_commit_t     x_commit_i,
  output logic          data_req_o,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  output logic          data_we_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_addr_o,
  output logic [31:0]   data_wdata_o,
  input  logic [31:0]   data_rdata_i,
  input  logic          data_err_i
);

  bridge_state_e       state_q, state_d;
  logic [XIdWidth-1:0] id_q, id_d;
  logic [31:2]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          offset_q, offset_d;
  logic                killed_q, killed_d;
  logic                committed_q, committed_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                req_q, req_d;
  logic                result_valid_q, result_valid_d;

  logic        handshake;
  logic        misaligned;
  logic        exc;
  logic        commit_new;
  logic        commit_cur;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  // Request fields the bridge deliberately does not act on.
  logic unused_req;
  assign unused_req = ^{x_mem_req_i.mode, x_mem_req_i.be, x_mem_req_i.attr, x_mem_req_i.last};

  xif_mem_lane_align u_lane_align (
    .size_i  (size_q),
    .offset_i(offset_q),
    .wdata_i (wdata_q),
    .rdata_i (data_rdata_i),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign handshake  = x_mem_valid_i & ready_q;
  assign misaligned = is_misaligned(x_mem_req_i.size, x_mem_req_i.addr[1:0]);
  assign exc        = handshake & misaligned & CheckAlign;
  assign commit_new = x_commit_valid_i & (x_commit_i.id == x_mem_req_i.id);
  assign commit_cur = x_commit_valid_i & (x_commit_i.id == id_q);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    we_d        = we_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    offset_d    = offset_q;
    killed_d    = killed_q;
    committed_d = committed_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          id_d        = x_mem_req_i.id;
          addr_d      = x_mem_req_i.addr[31:2];
          we_d        = x_mem_req_i.we;
          size_d      = x_mem_req_i.size;
          wdata_d     = x_mem_req_i.wdata;
          // With alignment checking off, a misaligned access collapses onto its word.
          offset_d    = misaligned ? 2'b00 : x_mem_req_i.addr[1:0];
          killed_d    = 1'b0;
          committed_d = commit_new & ~x_commit_i.commit_kill;
          rdata_d     = '0;
          err_d       = 1'b0;
          if (exc) begin
            err_d   = 1'b1;
            state_d = S_RESULT;
          end else if (x_mem_req_i.we && x_mem_req_i.spec) begin
            if (commit_new && x_commit_i.commit_kill) state_d = S_IDLE;
            else if (commit_new)                      state_d = S_BUS_REQ;
            else                                      state_d = S_WAIT_COMMIT;
          end else begin
            killed_d = x_mem_req_i.spec & commit_new & x_commit_i.commit_kill;
            state_d  = S_BUS_REQ;
          end
        end
      end

      S_WAIT_COMMIT: begin
        if (commit_cur) begin
          if (x_commit_i.commit_kill) begin
            state_d = S_IDLE;
          end else begin
            committed_d = 1'b1;
            state_d     = S_BUS_REQ;
          end
        end
      end

      S_BUS_REQ, S_BUS_WAIT: begin
        // Once on the bus the access runs to completion; a kill only suppresses the result.
        if (commit_cur) begin
          if (x_commit_i.commit_kill && !committed_q) killed_d    = 1'b1;
          else if (!x_commit_i.commit_kill)           committed_d = 1'b1;
        end
        if (state_q == S_BUS_REQ) begin
          if (data_gnt_i) state_d = S_BUS_WAIT;
        end else if (data_rvalid_i) begin
          rdata_d = we_q ? 32'h0 : lane_rdata;
          err_d   = data_err_i;
          state_d = S_RESULT;
        end
      end

      S_RESULT: begin
        killed_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    ready_d        = (state_d == S_IDLE);
    req_d          = (state_d == S_BUS_REQ);
    result_valid_d = (state_d == S_RESULT) & ~killed_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      id_q           <= '0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      size_q         <= '0;
      wdata_q        <= '0;
      offset_q       <= '0;
      killed_q       <= 1'b0;
      committed_q    <= 1'b0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      ready_q        <= 1'b0;
      req_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      size_q         <= size_d;
      wdata_q        <= wdata_d;
      offset_q       <= offset_d;
      killed_q       <= killed_d;
      committed_q    <= committed_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
      ready_q        <= ready_d;
      req_q          <= req_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign x_mem_ready_o        = ready_q;
  assign x_mem_resp_o.exc     = exc;
  assign x_mem_resp_o.exccode = exc ? (x_mem_req_i.we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN) : 6'd0;
  assign x_mem_resp_o.dbg     = 1'b0;

  assign x_mem_result_valid_o  = result_valid_q;
  assign x_mem_result_o.id     = id_q;
  assign x_mem_result_o.rdata  = rdata_q;
  assign x_mem_result_o.err    = err_q;
  assign x_mem_result_o.dbg    = 1'b0;

  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = lane_be;
  assign data_addr_o  = {addr_q, 2'b00};
  assign data_wdata_o = lane_wdata;

endmodule

// File: doc/test_xif_mem_bridge.md
Name: test_xif_mem_bridge

Overview:
- Downstream consumer of the pseudo load/store accelerator's XIF memory request interface.
- Accepts one x_mem request at a time and honours speculation and commit/kill from the XIF commit interface.
- Performs the access on the simple_system data bus (req/gnt/rvalid protocol), then returns the aligned load data through the XIF memory result interface.
- Lets the accelerator reach memory in the simple_system testbench without routing through the core's LSU.

Parameters:
- CheckAlign, 1'b1, when 1 misaligned accesses are rejected with an exception; when 0 the address is word-aligned silently.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- x_mem_valid_i  input  1  request valid from accelerator
- x_mem_ready_o  output  1  bridge can accept request
- x_mem_req_i  input  x_mem_req_t  request (id, addr, mode, we, size, be, attr, wdata, last, spec)
- x_mem_resp_o  output  x_mem_resp_t  response (exc, exccode, dbg), valid in handshake cycle
- x_mem_result_valid_o  output  1  result pulse
- x_mem_result_o  output  x_mem_result_t  result (id, rdata, err, dbg)
- x_commit_valid_i  input  1  commit valid
- x_commit_i  input  x_commit_t  commit id and commit_kill
- data_req_o  output  1  bus request
- data_gnt_i  input  1  bus grant
- data_rvalid_i  input  1  bus response valid
- data_we_o  output  1  bus write enable
- data_be_o  output  4  byte enables
- data_addr_o  output  32  word-aligned address
- data_wdata_o  output  32  lane-aligned write data
- data_rdata_i  input  32  read data
- data_err_i  input  1  bus error

Behaviour:
- Reset: FSM to IDLE. data_req_o, x_mem_result_valid_o and x_mem_ready_o are 0 during reset; x_mem_ready_o is 1 from the first cycle after reset. All captured registers (id, addr, we, size, wdata, offset, killed, committed) reset to 0.
- FSM states: IDLE, WAIT_COMMIT, BUS_REQ, BUS_WAIT, RESULT.
- IDLE:
  - x_mem_ready_o=1; a handshake is x_mem_valid_i & x_mem_ready_o.
  - On handshake, capture the request.
  - Misaligned is size=1 with addr[0]=1, or size=2 with addr[1:0]!=0. With CheckAlign=1 a misaligned request drives x_mem_resp_o.exc=1 combinationally in the handshake cycle, exccode 4 for a load and 6 for a store, and goes to RESULT with err=1. No bus access is made.
  - Otherwise exc=0, exccode=0.
  - A store with spec=1 goes to WAIT_COMMIT unless a non-kill commit for the same id arrives in the same cycle, in which case it goes to BUS_REQ.
  - A store with spec=1 and a same-cycle kill for its id returns to IDLE with no result.
  - Loads, whether speculative or not, go directly to BUS_REQ.
- WAIT_COMMIT:
  - Matching commit with kill: go to IDLE, no bus access, no result.
  - Matching commit without kill: go to BUS_REQ.
  - A non-matching id is ignored.
- BUS_REQ:
  - data_req_o=1 and bus outputs are held stable until data_gnt_i; on grant go to BUS_WAIT.
  - A matching kill during BUS_REQ sets killed_q; the request stays pending.
- BUS_WAIT:
  - On data_rvalid_i, register rdata as data_rdata_i >> (8*offset_q) and err as data_err_i, then go to RESULT.
  - A matching kill still sets killed_q.
- RESULT:
  - x_mem_result_valid_o=1 for exactly one cycle unless killed_q=1; the result carries id_q.
  - Then go to IDLE and clear killed_q.
  - Total load latency with gnt in the first request cycle and rvalid one cycle later: handshake at t0, req at t1, rvalid at t2, result at t3.
- Lane mapping:
  - offset = addr[1:0]; data_addr_o = {addr[31:2],2'b00}.
  - be: size0 gives 4'b0001<<offset, size1 gives 4'b0011<<offset, size2 gives 4'b1111. The incoming x_mem_req_i.be is ignored.
  - data_wdata_o = wdata << (8*offset).
  - Store results carry rdata=0.
- x_mem_result_o.dbg=0 and x_mem_resp_o.dbg=0 always.
- A commit for an id with no transaction pending is ignored.

Decomposition:
- Add the FSM enum and the exception-code constants EXC_LD_MISALIGN=4 and EXC_ST_MISALIGN=6 to ibex_pkg, or reuse the existing exc_cause enums.
- One combinational sub-module, xif_mem_lane_align: (size, offset, wdata, rdata) -> (be, wdata_shifted, rdata_shifted).

Test Plan:
- lw addr 0x1000_0008, spec=1; gnt immediately, rvalid next cycle with 0xDEADBEEF -> be=1111, addr 0x1000_0008, one result pulse with rdata 0xDEADBEEF, err=0, at handshake+3.
- lb addr 0x1000_0003; bus returns 0xAB00_0000 -> be=1000, result rdata 0x0000_00AB.
- sh addr 0x1000_0002, wdata 0x1234, spec=1; commit arrives 5 cycles later without kill -> no data_req_o before the commit, then be=1100 and data_wdata_o 0x1234_0000.
- sw spec=1 with commit_kill for the same id in WAIT_COMMIT -> no data_req_o, no result, x_mem_ready_o back to 1 the next cycle.
- lw addr 0x1000_0001, CheckAlign=1 -> exc=1, exccode=4 in the handshake cycle, no bus access, result err=1.
- lw with kill during BUS_WAIT and rvalid 2 cycles later -> bus completes, no result pulse. Also assert rst_ni mid-BUS_REQ -> data_req_o=0 at once and FSM in IDLE.
